// File: rtl/mux_41_rr_arbiter.sv
// mux_41_rr_arbiter: round-robin 4:1 mux select arbiter (clk, rst, req[3:0] in; gnt[3:0], s1, s0, busy registered out)
module mux_41_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy
);
  localparam int CW = $clog2(HOLD_MAX) + 1;
  localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel, sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] gnt_n, cand;
  logic [2:0] win;
  logic rel;
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] k;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction
  always_comb begin
    rel = (state == GRANT) && (!req[sel] || (cnt == CMAX && (req & ~gnt) != 4'b0));
    cand = rel ? req & ~gnt : req;
    ptr_n = rel ? sel + 2'd1 : ptr;
    win = pick(cand, ptr_n);
    state_n = state;
    gnt_n = gnt;
    sel_n = sel;
    cnt_n = cnt;
    if (state == IDLE || rel) begin
      state_n = win[2] ? GRANT : IDLE;
      gnt_n = win[2] ? 4'b1 << win[1:0] : 4'b0;
      sel_n = win[2] ? win[1:0] : sel;
      cnt_n = '0;
    end else begin
      cnt_n = (cnt == CMAX) ? '0 : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      cnt <= '0;
      gnt <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
      cnt <= cnt_n;
      gnt <= gnt_n;
      busy <= |gnt_n;
    end
  end
  assign s1 = sel[1];
  assign s0 = sel[0];
endmodule

// File: tb/tb_mux_41_rr_arbiter.sv
// tb_mux_41_rr_arbiter: vector table, directed sequences and random run against a queue-free behavioural model
module tb_mux_41_rr_arbiter;
  localparam int HOLD = 8;
  logic clk = 0, rst = 1;
  logic [3:0] req = '0, gnt;
  logic s1, s0, busy;
  int tests = 0, fails = 0;
  int m_owner = -1, m_ptr = 0, m_held = 0;
  logic [1:0] m_sel = '0;
  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic busy;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  mux_41_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .s1(s1), .s0(s0), .busy(busy)
  );
  function automatic void add(logic r, logic [3:0] q, logic [3:0] g, logic [1:0] s, logic b);
    vecs.push_back('{r, q, g, s, b});
  endfunction
  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step(logic r, logic [3:0] q);
    int w;
    logic [3:0] others;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = '0;
      return;
    end
    if (m_owner >= 0) begin
      others = q & ~(4'b1 << m_owner);
      if (!q[m_owner] || (m_held == HOLD && others != 0)) begin
        m_ptr = (m_owner + 1) % 4;
        q = others;
        m_owner = -1;
      end else begin
        m_held = (m_held == HOLD) ? 1 : m_held + 1;
        return;
      end
    end
    w = -1;
    for (int i = 3; i >= 0; i--) if (q[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
    if (w >= 0) begin
      m_owner = w; m_sel = 2'(w); m_held = 1;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step(rst, req);
    #1;
    chk("onehot", {3'b0, $onehot0(gnt)}, 4'd1);
    chk("busy_eq_or", {3'b0, busy}, {3'b0, |gnt});
    if (gnt != 0) chk("sel_idx", gnt, 4'b1 << {s1, s0});
  endtask
  task automatic chk_model(string name);
    chk({name, "_gnt"}, gnt, m_owner < 0 ? 4'b0 : 4'b1 << m_owner);
    chk({name, "_sel"}, {2'b0, s1, s0}, {2'b0, m_sel});
    chk({name, "_busy"}, {3'b0, busy}, {3'b0, m_owner >= 0});
  endtask
  task automatic chk_exp(string name, logic [3:0] g, logic [1:0] s, logic b);
    chk({name, "_gnt"}, gnt, g);
    chk({name, "_sel"}, {2'b0, s1, s0}, {2'b0, s});
    chk({name, "_busy"}, {3'b0, busy}, {3'b0, b});
  endtask
  initial begin
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    for (int i = 0; i < 7; i++) add(0, 4'b0011, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0010, 2'd1, 1);
    add(0, 4'b0011, 4'b0010, 2'd1, 1);
    add(0, 4'b0011, 4'b0010, 2'd1, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1);
    add(0, 4'b0000, 4'b0000, 2'd2, 0);
    add(0, 4'b1001, 4'b1000, 2'd3, 1);
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 4'b1000, 2'd3, 1);
    add(1, 4'b1111, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1);
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      tick();
      chk_exp($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy);
      chk_model($sformatf("vec%0d_model", i));
    end
    rst = 1; req = 4'b0100;
    tick();
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_exp($sformatf("single%0d", k), 4'b0100, 2'd2, 1);
    end
    req = 4'b0000;
    tick();
    chk_exp("single_drop", 4'b0000, 2'd2, 0);
    tick();
    chk_exp("idle_hold_sel", 4'b0000, 2'd2, 0);
    rst = 1; req = 4'b1111;
    tick();
    rst = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      chk_exp($sformatf("fair%0d", k), 4'b1 << ((k / HOLD) % 4), 2'((k / HOLD) % 4), 1);
    end
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = ($urandom_range(0, 3) == 0) ? req : 4'($urandom_range(0, 15));
      tick();
      chk_model($sformatf("rand%0d", k));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
